// File: rtl/dpa_photo_xfer_ctrl.sv
// Photo-transfer sequencer: reads a 128/256/512 source photo and writes an FB_DIM square image
// (2x2 average, copy, or 2x2 replicate). Optional auto-start timer: DPA_PERIOD_TIMER_EN.
module dpa_photo_xfer_ctrl #(
  parameter int unsigned ADDR_W = 20,
  parameter int unsigned FB_DIM = 256,
  parameter int unsigned PERIOD = 1000000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] photo_addr,
  input  logic [1:0]        photo_size,
  input  logic [ADDR_W-1:0] fb_addr,
  output logic [ADDR_W-1:0] im_a,
  output logic              im_wen_n,
  output logic              acc_clr,
  output logic              acc_en,
  output logic [1:0]        avg_shift,
  output logic              en_so,
  output logic              busy,
  output logic              done
);

  localparam int unsigned FB_LOG = $clog2(FB_DIM);

  typedef logic [ADDR_W-1:0] addr_t;
  typedef enum logic [2:0] {IDLE, READ, CAP, WRITE, FIN} state_t;
  typedef enum logic [1:0] {M128, M256, M512} mode_t;

  state_t      state, state_d;
  mode_t       mode;
  addr_t       photo_base, fb_base;
  logic [9:0]  x, y, x_d, y_d;
  logic [1:0]  sub, sub_d;
  logic        start_any;

`ifdef DPA_PERIOD_TIMER_EN
  logic [31:0] tmr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                       tmr <= '0;
    else if (tmr == 32'(PERIOD - 1)) tmr <= '0;
    else                             tmr <= tmr + 32'd1;
  end

  assign start_any = start | (tmr == '0);
`else
  assign start_any = start;
`endif

  logic        accept;
  assign accept = (state == IDLE) && start_any;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      mode       <= M256;
      photo_base <= '0;
      fb_base    <= '0;
      x          <= '0;
      y          <= '0;
      sub        <= '0;
      acc_en     <= 1'b0;
    end else begin
      state  <= state_d;
      x      <= x_d;
      y      <= y_d;
      sub    <= sub_d;
      acc_en <= (state == READ);
      if (accept) begin
        photo_base <= photo_addr;
        fb_base    <= fb_addr;
        case (photo_size)
          2'b01:   mode <= M128;
          2'b11:   mode <= M512;
          default: mode <= M256;
        endcase
      end
    end
  end

  logic [1:0] rd_last, wr_last;
  logic [9:0] grp_last;
  always_comb begin
    rd_last  = (mode == M512) ? 2'd3 : 2'd0;
    wr_last  = (mode == M128) ? 2'd3 : 2'd0;
    grp_last = (mode == M128) ? 10'd127 : 10'(FB_DIM - 1);
  end

  // Sub-index bit 0 selects the odd column, bit 1 the odd row of a 2x2 block.
  logic [10:0] blk_x, blk_y;
  addr_t       rd_off, wr_off;
  always_comb begin
    blk_x = {x, sub[0]};
    blk_y = {y, sub[1]};
    case (mode)
      M512:    rd_off = (addr_t'(blk_y) << 9) + addr_t'(blk_x);
      M128:    rd_off = (addr_t'(y) << 7) + addr_t'(x);
      default: rd_off = (addr_t'(y) << 8) + addr_t'(x);
    endcase
    if (mode == M128) wr_off = (addr_t'(blk_y) << FB_LOG) + addr_t'(blk_x);
    else              wr_off = (addr_t'(y) << FB_LOG) + addr_t'(x);
  end

  always_comb begin
    state_d = state;
    x_d     = x;
    y_d     = y;
    sub_d   = sub;
    case (state)
      IDLE: begin
        x_d   = '0;
        y_d   = '0;
        sub_d = '0;
        if (start_any) state_d = READ;
      end
      READ: begin
        // sub is held into CAP so im_a keeps the last read address
        if (sub == rd_last) state_d = CAP;
        else                sub_d   = sub + 2'd1;
      end
      CAP: begin
        state_d = WRITE;
        sub_d   = '0;
      end
      WRITE: begin
        if (sub == wr_last) begin
          sub_d = '0;
          if (x == grp_last) begin
            x_d = '0;
            if (y == grp_last) begin
              state_d = FIN;
            end else begin
              y_d     = y + 10'd1;
              state_d = READ;
            end
          end else begin
            x_d     = x + 10'd1;
            state_d = READ;
          end
        end else begin
          sub_d = sub + 2'd1;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    im_a      = '0;
    im_wen_n  = 1'b1;
    acc_clr   = 1'b0;
    en_so     = 1'b0;
    case (state)
      READ: begin
        im_a    = photo_base + rd_off;
        acc_clr = (sub == 2'd0);
      end
      CAP:   im_a = photo_base + rd_off;
      WRITE: begin
        im_a     = fb_base + wr_off;
        im_wen_n = 1'b0;
        en_so    = 1'b1;
      end
      default: ;
    endcase
    busy      = (state != IDLE);
    done      = (state == FIN);
    avg_shift = (busy && mode == M512) ? 2'd2 : 2'd0;
  end

endmodule
